// File: rtl/alu_lane_sequencer.sv
// ============================================================================
// Module   : alu_lane_sequencer
// Brief    : Splits a full-warp request into lane-width packets for a narrow ALU,
//            skipping all-inactive packets and tagging pid/sop/eop for regather.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_lane_sequencer #(
  parameter int THREAD_CNT = 4,
  parameter int NUM_LANES  = 2,
  parameter int DATAW      = 32,
  parameter int TAG_W      = 8,
  localparam int NUM_PKTS  = THREAD_CNT / NUM_LANES,
  localparam int PID_W     = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [THREAD_CNT-1:0]         in_tmask,
  input  logic [THREAD_CNT*DATAW-1:0]   in_data,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES-1:0]          out_tmask,
  output logic [NUM_LANES*DATAW-1:0]    out_data,
  output logic [TAG_W-1:0]              out_tag,
  output logic [PID_W-1:0]              out_pid,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [THREAD_CNT-1:0]       tmask_q;
  logic [THREAD_CNT*DATAW-1:0] data_q;
  logic [TAG_W-1:0]            tag_q;
  logic [PID_W-1:0]            pid_q;
  logic [PID_W-1:0]            pid_next;
  logic [PID_W-1:0]            first_pid;
  logic [NUM_PKTS-1:0]         nz_in;
  logic [NUM_PKTS-1:0]         nz_q;
  logic [NUM_PKTS-1:0]         above;
  logic                        sop_q;
  logic                        eop;
  logic                        accept;
  logic                        fire;
  int                          lane_base;

  for (genvar p = 0; p < NUM_PKTS; p++) begin : g_nz
    assign nz_in[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
  end

  assign accept = in_valid && (state == IDLE);
  assign fire   = out_valid && out_ready;

  // Scanning downward lets the last hit be the lowest qualifying packet index.
  always_comb begin
    above     = '0;
    first_pid = '0;
    pid_next  = pid_q;
    for (int p = NUM_PKTS - 1; p >= 0; p--) begin
      if (nz_in[p]) begin
        first_pid = PID_W'(p);
      end
      if (nz_q[p] && (p > int'(pid_q))) begin
        above[p] = 1'b1;
        pid_next = PID_W'(p);
      end
    end
    eop = ~|above;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)            state_next = ISSUE;
      ISSUE:   if (out_ready && eop)    state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmask_q <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      nz_q    <= '0;
      pid_q   <= '0;
      sop_q   <= 1'b0;
    end else if (accept) begin
      tmask_q <= in_tmask;
      data_q  <= in_data;
      tag_q   <= in_tag;
      nz_q    <= nz_in;
      pid_q   <= first_pid;
      sop_q   <= 1'b1;
    end else if (fire) begin
      sop_q <= 1'b0;
      if (!eop) begin
        pid_q <= pid_next;
      end
    end
  end

  // Outputs decode only captured state, so no input reaches an output combinationally.
  always_comb begin
    lane_base = int'(pid_q) * NUM_LANES;
    out_tmask = tmask_q[lane_base +: NUM_LANES];
    out_data  = data_q[lane_base*DATAW +: NUM_LANES*DATAW];
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == ISSUE);
  assign busy      = (state == ISSUE);
  assign out_tag   = tag_q;
  assign out_pid   = pid_q;
  assign out_sop   = out_valid && sop_q;
  assign out_eop   = out_valid && eop;

endmodule

`default_nettype wire
